// File: rtl/ahb_rsa2048_slave_if.sv
// AHB-Lite slave-side bus bundle for the modular exponentiation engine.
// The master modport drives requests, the slave modport drives responses.
interface ahb_rsa2048_slave_if;
  logic        sHSEL;
  logic [31:0] sHADDR;
  logic [1:0]  sHTRANS;
  logic        sHWRITE;
  logic [2:0]  sHSIZE;
  logic [2:0]  sHBURST;
  logic [31:0] sHWDATA;
  logic [31:0] sHRDATA;
  logic [1:0]  sHRESP;
  logic        sHREADYin;
  logic        sHREADYout;

  modport master (
    output sHSEL, sHADDR, sHTRANS, sHWRITE, sHSIZE, sHBURST, sHWDATA, sHREADYin,
    input  sHRDATA, sHRESP, sHREADYout
  );

  modport slave (
    input  sHSEL, sHADDR, sHTRANS, sHWRITE, sHSIZE, sHBURST, sHWDATA, sHREADYin,
    output sHRDATA, sHRESP, sHREADYout
  );
endinterface

// File: rtl/ahb_rsa2048_slave.sv
// AHB-Lite slave computing R = X^E mod M with bit-serial Blakley modular
// multiplication and left-to-right square-and-multiply.
// Optional feature macro: AHB_SIZE_ERR_EN -- when defined, non-word or
// misaligned transfers get a two-cycle ERROR response and change nothing.
//
// state   | meaning
// S_IDLE  | waiting for START, result and status held
// S_CHK   | first cycle after START: trap M==0, seed accumulator
// S_SETUP | load multiplier operands for the next modmul, clear p
// S_RUN   | one partial-product step per cycle, WIDTH cycles
module ahb_rsa2048_slave #(
  parameter int WIDTH = 2048
) (
  input logic           HCLK,
  input logic           HRESETn,
  ahb_rsa2048_slave_if.slave bus
);

  localparam int NW = WIDTH / 32;
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {S_IDLE, S_CHK, S_SETUP, S_RUN} state_t;

  // operand, result and status registers
  logic [WIDTH-1:0] x_q, e_q, m_q, r_q;
  logic             busy_q, done_q, err_q;

  // bus pipeline registers
  logic             wr_pend_q;
  logic [10:0]      waddr_q;
  logic [31:0]      hrdata_q;
  logic             err1_q, err2_q;

  // engine registers
  state_t           state_q;
  logic [WIDTH-1:0] acc_q, mm_a_q, mm_b_q;
  logic [WIDTH+1:0] p_q;
  logic [CW-1:0]    cnt_q, ebit_q;
  logic             is_sq_q;

  logic             addr_ok, bad_xfer;
  logic [31:0]      rd_word;
  logic [2:0]       wregion;
  logic [5:0]       widx;
  logic             wr_ctrl, start, clr_done, wr_x, wr_e, wr_m;
  logic [WIDTH+1:0] t0, t1, t2, m_ext;

  assign addr_ok = bus.sHSEL & bus.sHTRANS[1] & bus.sHREADYin;

`ifdef AHB_SIZE_ERR_EN
  assign bad_xfer = (bus.sHSIZE != 3'b010) || (bus.sHADDR[1:0] != 2'b00);
`else
  assign bad_xfer = 1'b0;
`endif

  wire unused_ok = ^{bus.sHBURST, bus.sHADDR[31:11], bus.sHADDR[1:0],
                     bus.sHSIZE, p_q[WIDTH+1]};

  function automatic logic [31:0] pick(input logic [WIDTH-1:0] v, input logic [5:0] idx);
    logic [31:0] w;
    w = '0;
    for (int i = 0; i < NW; i++) begin
      if (idx == 6'(i)) w = v[32*i +: 32];
    end
    return w;
  endfunction

  // read mux evaluated on the address-phase address
  always_comb begin
    rd_word = '0;
    case (bus.sHADDR[10:8])
      3'd0:    if (bus.sHADDR[7:2] == 6'd1) rd_word = {29'd0, err_q, done_q, busy_q};
      3'd1:    rd_word = pick(x_q, bus.sHADDR[7:2]);
      3'd2:    rd_word = pick(e_q, bus.sHADDR[7:2]);
      3'd3:    rd_word = pick(m_q, bus.sHADDR[7:2]);
      3'd4:    rd_word = pick(r_q, bus.sHADDR[7:2]);
      default: rd_word = '0;
    endcase
  end

  // capture address phase, read data and error response sequencing
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      wr_pend_q <= 1'b0;
      waddr_q   <= '0;
      hrdata_q  <= '0;
      err1_q    <= 1'b0;
      err2_q    <= 1'b0;
    end else begin
      err1_q    <= addr_ok & bad_xfer;
      err2_q    <= err1_q;
      wr_pend_q <= addr_ok & bus.sHWRITE & ~bad_xfer;
      if (addr_ok) waddr_q <= bus.sHADDR[10:0];
      hrdata_q  <= (addr_ok & ~bus.sHWRITE & ~bad_xfer) ? rd_word : 32'd0;
    end
  end

  assign bus.sHRDATA    = hrdata_q;
  assign bus.sHRESP     = (err1_q | err2_q) ? 2'b01 : 2'b00;
  assign bus.sHREADYout = ~err1_q;

  assign wregion  = waddr_q[10:8];
  assign widx     = waddr_q[7:2];
  assign wr_ctrl  = wr_pend_q && (wregion == 3'd0) && (widx == 6'd0);
  assign start    = wr_ctrl && bus.sHWDATA[0] && !busy_q;
  assign clr_done = wr_ctrl && bus.sHWDATA[1];
  assign wr_x     = wr_pend_q && (wregion == 3'd1) && !busy_q;
  assign wr_e     = wr_pend_q && (wregion == 3'd2) && !busy_q;
  assign wr_m     = wr_pend_q && (wregion == 3'd3) && !busy_q;

  // operand words written in the data phase; frozen while the engine runs
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      x_q <= '0;
      e_q <= '0;
      m_q <= '0;
    end else begin
      for (int i = 0; i < NW; i++) begin
        if (wr_x && widx == 6'(i)) x_q[32*i +: 32] <= bus.sHWDATA;
        if (wr_e && widx == 6'(i)) e_q[32*i +: 32] <= bus.sHWDATA;
        if (wr_m && widx == 6'(i)) m_q[32*i +: 32] <= bus.sHWDATA;
      end
    end
  end

  // one Blakley step: p = 2p + (a_msb ? b : 0), then at most two subtractions of M
  always_comb begin
    m_ext = {2'b00, m_q};
    t0    = {p_q[WIDTH:0], 1'b0} + (mm_a_q[WIDTH-1] ? {2'b00, mm_b_q} : {(WIDTH+2){1'b0}});
    t1    = (t0 >= m_ext) ? (t0 - m_ext) : t0;
    t2    = (t1 >= m_ext) ? (t1 - m_ext) : t1;
  end

  // exponentiation sequencer with registered status and result
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q <= S_IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      r_q     <= '0;
      acc_q   <= '0;
      mm_a_q  <= '0;
      mm_b_q  <= '0;
      p_q     <= '0;
      cnt_q   <= '0;
      ebit_q  <= '0;
      is_sq_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            state_q <= S_CHK;
          end else if (clr_done) begin
            done_q <= 1'b0;
          end
        end
        S_CHK: begin
          if (m_q == '0) begin
            err_q   <= 1'b1;
            r_q     <= '0;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end else begin
            // 1 mod M is 0 when M==1, so the seed must already be reduced
            acc_q   <= (m_q == WIDTH'(1)) ? '0 : WIDTH'(1);
            ebit_q  <= CW'(WIDTH - 1);
            is_sq_q <= 1'b1;
            state_q <= S_SETUP;
          end
        end
        S_SETUP: begin
          mm_a_q  <= acc_q;
          mm_b_q  <= is_sq_q ? acc_q : x_q;
          p_q     <= '0;
          cnt_q   <= CW'(WIDTH - 1);
          state_q <= S_RUN;
        end
        S_RUN: begin
          p_q    <= t2;
          mm_a_q <= {mm_a_q[WIDTH-2:0], 1'b0};
          cnt_q  <= cnt_q - CW'(1);
          if (cnt_q == '0) begin
            acc_q <= t2[WIDTH-1:0];
            if (is_sq_q && e_q[ebit_q]) begin
              is_sq_q <= 1'b0;
              state_q <= S_SETUP;
            end else if (ebit_q == '0) begin
              r_q     <= t2[WIDTH-1:0];
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= S_IDLE;
            end else begin
              ebit_q  <= ebit_q - CW'(1);
              is_sq_q <= 1'b1;
              state_q <= S_SETUP;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ahb_rsa2048_slave.sv
// Directed and randomized bench for ahb_rsa2048_slave at WIDTH=64.
// Optional feature macro: AHB_SIZE_ERR_EN selects the error-response checks.
module tb_ahb_rsa2048_slave;
  localparam int W = 64;

  logic HCLK    = 1'b0;
  logic HRESETn = 1'b0;
  int   total   = 0;
  int   bad     = 0;

  ahb_rsa2048_slave_if bif();
  assign bif.sHREADYin = bif.sHREADYout;

  ahb_rsa2048_slave #(.WIDTH(W)) dut (
    .HCLK   (HCLK),
    .HRESETn(HRESETn),
    .bus    (bif)
  );

  always #5 HCLK = ~HCLK;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // right-to-left exponentiation with plain 128-bit arithmetic
  function automatic logic [63:0] ref_modexp(input logic [63:0] x, input logic [63:0] e,
                                             input logic [63:0] m);
    logic [127:0] r, b, mm;
    if (m == 64'd0) return 64'd0;
    mm = {64'd0, m};
    r  = 128'd1 % mm;
    b  = {64'd0, x} % mm;
    for (int i = 0; i < 64; i++) begin
      if (e[i]) r = (r * b) % mm;
      b = (b * b) % mm;
    end
    return r[63:0];
  endfunction

  task automatic bus_idle();
    bif.sHSEL   = 1'b0;
    bif.sHTRANS = 2'b00;
    bif.sHWRITE = 1'b0;
    bif.sHSIZE  = 3'b010;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    bif.sHSEL = 1'b1; bif.sHTRANS = 2'b10; bif.sHWRITE = 1'b1;
    bif.sHADDR = a; bif.sHSIZE = 3'b010;
    @(posedge HCLK); #1;
    bus_idle();
    bif.sHWDATA = d;
    @(posedge HCLK); #1;
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] d);
    bif.sHSEL = 1'b1; bif.sHTRANS = 2'b10; bif.sHWRITE = 1'b0;
    bif.sHADDR = a; bif.sHSIZE = 3'b010;
    @(posedge HCLK); #1;
    bus_idle();
    d = bif.sHRDATA;
  endtask

  task automatic load(input logic [63:0] x, input logic [63:0] e, input logic [63:0] m);
    wr(32'h100, x[31:0]); wr(32'h104, x[63:32]);
    wr(32'h200, e[31:0]); wr(32'h204, e[63:32]);
    wr(32'h300, m[31:0]); wr(32'h304, m[63:32]);
  endtask

  task automatic read_r(output logic [63:0] r);
    logic [31:0] lo, hi;
    rd(32'h400, lo);
    rd(32'h404, hi);
    r = {hi, lo};
  endtask

  task automatic wait_idle(input string tag, output logic [31:0] st);
    st = 32'h1;
    for (int k = 0; k < 20000; k++) begin
      rd(32'h004, st);
      if (!st[0]) break;
    end
    chk({tag, "_busy_clears"}, {63'd0, st[0]}, 64'd0);
  endtask

  task automatic run(input logic [63:0] x, input logic [63:0] e, input logic [63:0] m,
                     input logic [63:0] exp, input string tag);
    logic [31:0] st;
    logic [63:0] r;
    load(x, e, m);
    wr(32'h000, 32'h1);
    wait_idle(tag, st);
    chk({tag, "_status"}, {32'd0, st}, 64'h2);
    read_r(r);
    chk({tag, "_result"}, r, exp);
  endtask

  initial begin
    logic [31:0] d;
    logic [63:0] r, x, e, m;

    bus_idle();
    bif.sHADDR  = '0;
    bif.sHBURST = 3'b000;
    bif.sHWDATA = '0;

    // reset
    repeat (10) @(posedge HCLK);
    #1;
    chk("rst_ready", {63'd0, bif.sHREADYout}, 64'd1);
    chk("rst_resp", {62'd0, bif.sHRESP}, 64'd0);
    chk("rst_rdata", {32'd0, bif.sHRDATA}, 64'd0);
    HRESETn = 1'b1;
    @(posedge HCLK); #1;
    rd(32'h004, d); chk("rst_status", {32'd0, d}, 64'd0);
    rd(32'h400, d); chk("rst_r0", {32'd0, d}, 64'd0);

    // directed results
    run(64'd4, 64'd13, 64'd497, 64'd445, "x4e13m497");
    run(64'd2, 64'd10, 64'd1000, 64'd24, "x2e10m1000");

    // M==0 error path
    load(64'd9, 64'd5, 64'd0);
    wr(32'h000, 32'h1);
    @(posedge HCLK); #1;
    rd(32'h004, d); chk("m0_status", {32'd0, d}, 64'h6);
    rd(32'h400, d); chk("m0_r0", {32'd0, d}, 64'd0);
    wr(32'h000, 32'h2);
    rd(32'h004, d); chk("m0_clr_done", {32'd0, d}, 64'h4);

    run(64'd3, 64'd0, 64'd7, 64'd1, "e0");

    // start and clear together: start wins, DONE cleared
    load(64'd5, 64'd3, 64'd1);
    wr(32'h000, 32'h3);
    rd(32'h004, d); chk("start_clr_status", {32'd0, d}, 64'h1);
    wait_idle("m1", d);
    read_r(r); chk("m1_result", r, 64'd0);

    // randomized operands
    for (int n = 0; n < 3; n++) begin
      m = {$urandom, $urandom};
      if (m == 64'd0) m = 64'd1;
      x = {$urandom, $urandom} % m;
      e = {$urandom, $urandom};
      run(x, e, m, ref_modexp(x, e, m), "rand");
    end

    // unmapped and read-only accesses
    rd(32'h500, d); chk("unmapped_rd", {32'd0, d}, 64'd0);
    rd(32'h000, d); chk("ctrl_rd", {32'd0, d}, 64'd0);
    read_r(r);
    wr(32'h400, 32'hDEAD_BEEF);
    read_r(x); chk("r_write_ignored", x, r);

    // writes and START while busy are ignored
    load(64'd4, 64'd13, 64'd497);
    wr(32'h000, 32'h1);
    rd(32'h004, d); chk("busy_status", {32'd0, d}, 64'h1);
    wr(32'h300, 32'h0000_FFFF);
    rd(32'h300, d); chk("busy_m0_kept", {32'd0, d}, 64'd497);
    wr(32'h000, 32'h1);
    wait_idle("busy", d);
    read_r(r); chk("busy_result", r, 64'd445);

    // reset aborts an operation and clears everything
    wr(32'h000, 32'h1);
    repeat (50) @(posedge HCLK);
    #1 HRESETn = 1'b0;
    repeat (3) @(posedge HCLK);
    #1 HRESETn = 1'b1;
    @(posedge HCLK); #1;
    rd(32'h004, d); chk("abort_status", {32'd0, d}, 64'd0);
    rd(32'h100, d); chk("abort_x0", {32'd0, d}, 64'd0);
    rd(32'h200, d); chk("abort_e0", {32'd0, d}, 64'd0);
    rd(32'h300, d); chk("abort_m0", {32'd0, d}, 64'd0);
    rd(32'h400, d); chk("abort_r0", {32'd0, d}, 64'd0);

    // byte-size write to X[0]
    bif.sHSEL = 1'b1; bif.sHTRANS = 2'b10; bif.sHWRITE = 1'b1;
    bif.sHADDR = 32'h100; bif.sHSIZE = 3'b000;
    @(posedge HCLK); #1;
    bus_idle();
    bif.sHWDATA = 32'h0000_00A5;
`ifdef AHB_SIZE_ERR_EN
    chk("err_c1_ready", {63'd0, bif.sHREADYout}, 64'd0);
    chk("err_c1_resp", {62'd0, bif.sHRESP}, 64'd1);
    @(posedge HCLK); #1;
    chk("err_c2_ready", {63'd0, bif.sHREADYout}, 64'd1);
    chk("err_c2_resp", {62'd0, bif.sHRESP}, 64'd1);
    @(posedge HCLK); #1;
    chk("err_after_resp", {62'd0, bif.sHRESP}, 64'd0);
    rd(32'h100, d); chk("err_x0_kept", {32'd0, d}, 64'd0);
`else
    chk("byte_ready", {63'd0, bif.sHREADYout}, 64'd1);
    chk("byte_resp", {62'd0, bif.sHRESP}, 64'd0);
    @(posedge HCLK); #1;
    rd(32'h100, d); chk("byte_x0_written", {32'd0, d}, 64'hA5);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
